bram_port_arbiter: RTL and testbench

Round-robin arbiter that shares one port of a single-port or true-dual-port BRAM among NUM_REQ requesters. Each requester uses a valid/ready request handshake. Accepted requests are registered onto the BRAM port, and read data is routed back to the issuing requester. The block sits between client engines and one BRAM port; the other BRAM port stays free for an independent agent.

---
 rtl/bram_port_arbiter.sv | 130 +++++++++++++
 tb/tb_bram_port_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port among NUM_REQ valid/ready requesters; read data routed back by id.
// Latency: issue 1 cycle after accept, response 1+RD_LATENCY cycles after accept; never stalls. Option: BRAM_ARB_LOCK_EN.
module bram_port_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int RAM_WIDTH     = 8,
    parameter int RAM_ADDR_BITS = 10,
    parameter int RD_LATENCY    = 1
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NUM_REQ-1:0]               req_valid_i,
    input  logic [NUM_REQ-1:0]               req_we_i,
    input  logic [NUM_REQ*RAM_ADDR_BITS-1:0] req_addr_i,
    input  logic [NUM_REQ*RAM_WIDTH-1:0]     req_data_i,
`ifdef BRAM_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]               req_lock_i,
`endif
    output logic [NUM_REQ-1:0]               req_ready_o,
    output logic [NUM_REQ-1:0]               rsp_valid_o,
    output logic [RAM_WIDTH-1:0]             rsp_data_o,
    output logic                             mem_en_o,
    output logic                             mem_we_o,
    output logic [RAM_ADDR_BITS-1:0]         mem_addr_o,
    output logic [RAM_WIDTH-1:0]             mem_data_o,
    input  logic [RAM_WIDTH-1:0]             mem_data_i
);
    localparam int PTR_W = $clog2(NUM_REQ);

    typedef struct packed {
        logic               rd;
        logic [NUM_REQ-1:0] id;
    } trk_t;

    logic [PTR_W-1:0]     ptr;
    logic [NUM_REQ-1:0]   grant;
    logic [PTR_W-1:0]     grant_id;
    logic                 grant_any;
    logic                 lock_hit;
    logic [PTR_W:0]       idx;
    trk_t                 pipe [RD_LATENCY+1];
    logic [RAM_WIDTH-1:0] rsp_hold;
    logic                 rsp_any;

`ifdef BRAM_ARB_LOCK_EN
    logic             last_vld;
    logic [PTR_W-1:0] last_id;

    assign lock_hit = last_vld && req_lock_i[last_id] && req_valid_i[last_id];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_vld <= 1'b0;
            last_id  <= '0;
        end else begin
            last_vld <= grant_any;
            if (grant_any)
                last_id <= grant_id;
        end
    end
`else
    assign lock_hit = 1'b0;
`endif

    // Scan from the pointer, wrapping; a held lock overrides the scan.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr} + (PTR_W+1)'(k);
            if (idx >= (PTR_W+1)'(NUM_REQ))
                idx = idx - (PTR_W+1)'(NUM_REQ);
            if (!grant_any && req_valid_i[idx[PTR_W-1:0]]) begin
                grant_any = 1'b1;
                grant_id  = idx[PTR_W-1:0];
            end
        end
`ifdef BRAM_ARB_LOCK_EN
        if (lock_hit) begin
            grant_any = 1'b1;
            grant_id  = last_id;
        end
`endif
        if (grant_any)
            grant[grant_id] = 1'b1;
    end

    assign req_ready_o = rst_ni ? grant : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr        <= '0;
            mem_en_o   <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
        end else begin
            mem_en_o <= grant_any;
            mem_we_o <= grant_any && req_we_i[grant_id];
            if (grant_any) begin
                mem_addr_o <= req_addr_i[grant_id*RAM_ADDR_BITS +: RAM_ADDR_BITS];
                mem_data_o <= req_data_i[grant_id*RAM_WIDTH +: RAM_WIDTH];
            end
            if (grant_any && !lock_hit)
                ptr <= (grant_id == PTR_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
        end
    end

    // Stage 0 lines up with the issue cycle; the last stage with BRAM read data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s <= RD_LATENCY; s++)
                pipe[s] <= '0;
            rsp_hold <= '0;
        end else begin
            pipe[0].rd <= grant_any && !req_we_i[grant_id];
            pipe[0].id <= grant;
            for (int s = 1; s <= RD_LATENCY; s++)
                pipe[s] <= pipe[s-1];
            if (rsp_any)
                rsp_hold <= mem_data_i;
        end
    end

    assign rsp_any     = pipe[RD_LATENCY].rd;
    assign rsp_valid_o = rsp_any ? pipe[RD_LATENCY].id : '0;
    assign rsp_data_o  = rsp_any ? mem_data_i : rsp_hold;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a behavioural 1-cycle BRAM model.
module tb_bram_port_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int AB = 10;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_we;
    logic [N*AB-1:0] req_addr;
    logic [N*W-1:0]  req_data;
`ifdef BRAM_ARB_LOCK_EN
    logic [N-1:0]    req_lock;
`endif
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [W-1:0]    rsp_data;
    logic            mem_en;
    logic            mem_we;
    logic [AB-1:0]   mem_addr;
    logic [W-1:0]    mem_wdata;
    logic [W-1:0]    mem_rdata;

    logic [W-1:0]    ram [1<<AB];
    int              errs   = 0;
    int              checks = 0;

    always #5 clk_i = ~clk_i;

    bram_port_arbiter #(.NUM_REQ(N), .RAM_WIDTH(W), .RAM_ADDR_BITS(AB), .RD_LATENCY(1)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_data_i  (req_data),
`ifdef BRAM_ARB_LOCK_EN
        .req_lock_i  (req_lock),
`endif
        .req_ready_o (req_ready),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .mem_en_o    (mem_en),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_data_o  (mem_wdata),
        .mem_data_i  (mem_rdata)
    );

    always @(posedge clk_i) begin
        if (mem_en) begin
            if (mem_we)
                ram[mem_addr] <= mem_wdata;
            else
                mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drv(input int i, input logic we, input logic [AB-1:0] a, input logic [W-1:0] d);
        req_valid[i]       = 1'b1;
        req_we[i]          = we;
        req_addr[i*AB +: AB] = a;
        req_data[i*W +: W]   = d;
    endtask

    function automatic logic [W-1:0] init_val(input logic [AB-1:0] a);
        return a[7:0] ^ 8'h3C;
    endfunction

    initial begin
        logic [AB-1:0] ra;
        for (int a = 0; a < (1 << AB); a++) begin
            ra = AB'(a);
            ram[a] = init_val(ra);
        end
        mem_rdata = '0;
        rst_ni    = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_data  = '0;
`ifdef BRAM_ARB_LOCK_EN
        req_lock  = '0;
`endif
        drv(0, 1'b0, 10'h001, 8'h00);
        cyc;
        @(negedge clk_i);
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 32'h0);
        check("rst_rsp", {rsp_valid, rsp_data}, 32'h0);
        req_valid = '0;
        cyc;
        rst_ni = 1'b1;

        // Idle
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            check("idle", {req_ready, mem_en, rsp_valid}, 32'h0);
            cyc;
        end

        // Write then read-back of the same address
        drv(0, 1'b1, 10'h010, 8'hA5);
        @(negedge clk_i);
        check("wr_grant", 32'(req_ready), 32'h1);
        cyc;
        drv(0, 1'b0, 10'h010, 8'h00);
        @(negedge clk_i);
        check("rd_grant", 32'(req_ready), 32'h1);
        check("wr_issue", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 10'h010, 8'hA5});
        cyc;
        req_valid = '0;
        @(negedge clk_i);
        check("rd_issue", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 10'h010});
        check("wr_no_rsp", 32'(rsp_valid), 32'h0);
        cyc;
        @(negedge clk_i);
        check("rd_rsp", {rsp_valid, rsp_data}, {4'b0001, 8'hA5});
        check("idle_en", {mem_en, mem_we, mem_addr}, {1'b0, 1'b0, 10'h010});
        cyc;
        @(negedge clk_i);
        check("rsp_hold", {rsp_valid, rsp_data}, {4'b0000, 8'hA5});
        cyc;

        // Everyone reads every cycle from pointer 0
        rst_ni = 1'b0;
        cyc;
        rst_ni = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c < 8)
                for (int i = 0; i < N; i++) drv(i, 1'b0, AB'(10'h040 + i), 8'h00);
            else
                req_valid = '0;
            @(negedge clk_i);
            if (c < 8)
                check("rr_grant", 32'(req_ready), 32'(1 << (c % 4)));
            if (c >= 1 && c <= 8)
                check("rr_issue", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, AB'(10'h040 + (c - 1) % 4)});
            if (c >= 2) begin
                ra = AB'(10'h040 + (c - 2) % 4);
                check("rr_rsp", {rsp_valid, rsp_data}, {4'(1 << ((c - 2) % 4)), init_val(ra)});
            end
            cyc;
        end

        // Req1 alone moves the pointer to 2, then req1+req3 contend
        drv(1, 1'b1, 10'h301, 8'h11);
        @(negedge clk_i);
        check("p2_setup", 32'(req_ready), 32'h2);
        cyc;
        drv(1, 1'b1, 10'h301, 8'h11);
        drv(3, 1'b1, 10'h303, 8'h33);
        @(negedge clk_i);
        check("p2_first", 32'(req_ready), 32'h8);
        cyc;
        @(negedge clk_i);
        check("p2_second", 32'(req_ready), 32'h2);
        cyc;
        req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            check("wr_silent", 32'(rsp_valid), 32'h0);
            cyc;
        end

        // Req0 and req2 contend from pointer 2; req2 may lock
        for (int c = 0; c < 4; c++) begin
            drv(0, 1'b0, 10'h050, 8'h00);
            if (c < 3) drv(2, 1'b0, 10'h052, 8'h00);
            else       req_valid[2] = 1'b0;
`ifdef BRAM_ARB_LOCK_EN
            req_lock = (c < 3) ? 4'b0100 : 4'b0000;
            check("lock_grant", 32'(req_ready), (c == 3) ? 32'h1 : 32'h4);
`endif
            @(negedge clk_i);
`ifdef BRAM_ARB_LOCK_EN
            check("lock_grant", 32'(req_ready), (c == 3) ? 32'h1 : 32'h4);
`else
            check("alt_grant", 32'(req_ready), (c % 2 == 0) ? 32'h4 : 32'h1);
`endif
            cyc;
        end
        req_valid = '0;
`ifdef BRAM_ARB_LOCK_EN
        req_lock  = '0;
`endif
        cyc;
        cyc;

        // Async reset with two reads in flight; pointer currently 1
        drv(1, 1'b0, 10'h061, 8'h00);
        @(negedge clk_i);
        check("flight_a", 32'(req_ready), 32'h2);
        cyc;
        req_valid = '0;
        drv(2, 1'b0, 10'h062, 8'h00);
        #1;
        check("flight_b", 32'(req_ready), 32'h4);
        #1;
        rst_ni = 1'b0;
        #1;
        check("arst_ready", 32'(req_ready), 32'h0);
        check("arst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 32'h0);
        check("arst_rsp", {rsp_valid, rsp_data}, 32'h0);
        cyc;
        cyc;
        req_valid = '0;
        drv(0, 1'b1, 10'h070, 8'h70);
        drv(3, 1'b1, 10'h073, 8'h73);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("post_rst_ptr", 32'(req_ready), 32'h1);
        check("post_rst_rsp", 32'(rsp_valid), 32'h0);
        cyc;
        @(negedge clk_i);
        check("post_rst_next", 32'(req_ready), 32'h8);
        check("post_rst_rsp", 32'(rsp_valid), 32'h0);
        cyc;
        req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            check("post_rst_rsp", 32'(rsp_valid), 32'h0);
            cyc;
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
